// File: rtl/serial_add_pkg.sv
// Shared constants and FSM state type for the nibble-serial adder.
package serial_add_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/nibble_add.sv
// Combinational 4-bit adder slice; the only arithmetic in serial_add_ctrl.
module nibble_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0, ci};
endmodule

// File: rtl/serial_add_ctrl.sv
// Nibble-serial add/subtract with valid/ready handshakes on both sides.
// Define SERIAL_ADD_SUB_EN to compile in subtraction (sub=1 -> a + ~b + 1).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N     = WIDTH / NIBBLE_W;
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, ovf_q, ovf_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [WIDTH-1:0] eff_b;
  logic             eff_c;
`ifdef SERIAL_ADD_SUB_EN
  assign eff_b = sub ? ~b : b;
  assign eff_c = sub ? 1'b1 : cin;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign eff_b      = b;
  assign eff_c      = cin;
`endif

  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_s;
  logic                nib_co;
  assign nib_a = a_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];
  assign nib_b = b_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];

  nibble_add u_nibble_add (
    .a (nib_a),
    .b (nib_b),
    .ci(carry_q),
    .s (nib_s),
    .co(nib_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a;
        b_d     = eff_b;
        carry_d = eff_c;
        idx_d   = '0;
        state_d = ADD;
      end
      ADD: begin
        sum_d[NIBBLE_W*int'(idx_q) +: NIBBLE_W] = nib_s;
        carry_d = nib_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          // nib_s[3] is the sum MSB being written on this edge
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_s[3] != a_q[WIDTH-1]);
          state_d = DONE;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  // carry register is frozen in DONE, so it doubles as cout
  assign cout      = carry_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized bench for serial_add_ctrl against an arithmetic reference model.
module tb_serial_add_ctrl;
  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {ovf, cout, sum} from plain wide arithmetic.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] oa, ob, input logic oc, os);
    logic [W-1:0] eb;
    logic         c0;
    logic [W:0]   full;
    eb = ob;
    c0 = oc;
`ifdef SERIAL_ADD_SUB_EN
    if (os) begin
      eb = ~ob;
      c0 = 1'b1;
    end
`else
    if (os) c0 = oc;
`endif
    full = {1'b0, oa} + {1'b0, eb} + (W+1)'(c0);
    return {(oa[W-1] == eb[W-1]) && (full[W-1] != oa[W-1]), full[W], full[W-1:0]};
  endfunction

  task automatic junk();
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
    sub = 1'($urandom);
  endtask

  task automatic run_op(input logic [W-1:0] oa, ob, input logic oc, os,
                        input int hold, input logic [W+1:0] e);
    chk("in_ready_idle", 32'(in_ready), 1);
    a = oa; b = ob; cin = oc; sub = os; in_valid = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= N; k++) begin
      junk();
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      chk("out_valid_lat", 32'(out_valid), 32'(k == N));
      chk("in_ready_busy", 32'(in_ready), 0);
    end
    chk("sum", 32'(sum), 32'(e[W-1:0]));
    chk("cout", 32'(cout), 32'(e[W]));
    chk("ovf", 32'(ovf), 32'(e[W+1]));
    for (int h = 0; h < hold; h++) begin
      junk();
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_ready", 32'(in_ready), 0);
      chk("hold_sum", 32'(sum), 32'(e[W-1:0]));
      chk("hold_flags", {30'd0, cout, ovf}, {30'd0, e[W], e[W+1]});
    end
    junk();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("consume_valid", 32'(out_valid), 0);
    chk("consume_ready", 32'(in_ready), 1);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc, rs;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_flags", {30'd0, cout, ovf}, 0);

    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, {1'b0, 1'b1, 16'h0000});
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1, {1'b1, 1'b0, 16'h8000});
    run_op(16'h1234, 16'h4321, 1'b1, 1'b0, 3, {1'b0, 1'b0, 16'h5556});
`ifdef SERIAL_ADD_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, {1'b0, 1'b0, 16'hFFFE});
`else
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, {1'b0, 1'b0, 16'h000C});
`endif

    // Reset two cycles into ADD: the partial result must never surface.
    a = 16'hABCD; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_sum", 32'(sum), 0);
    chk("midrst_flags", {30'd0, cout, ovf}, 0);
    for (int i = 0; i < 2 * N; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_result", 32'(out_valid), 0);
    end

    for (int t = 0; t < 60; t++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      if (t % 8 == 0) rb = ~ra;
      if (t % 8 == 1) begin ra = 16'h8000; rb = 16'h8000; end
      run_op(ra, rb, rc, rs, int'($urandom_range(0, 3)), ref_add(ra, rb, rc, rs));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
